// File: rtl/iob_vexriscv_bus_arb.sv
// 2:1 VexRiscv I/D IOb arbiter onto one memory port, in-order read ID FIFO.
// Define IOB_VEXRISCV_ARB_DPRIO_EN for fixed D priority instead of round-robin.
module iob_vexriscv_bus_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                i_avalid_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_ready_o,
    output logic                i_rvalid_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    input  logic                d_avalid_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic                d_ready_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                m_avalid_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic                m_ready_i,
    input  logic                m_rvalid_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    output logic                err_o
);

    localparam int SW = DATA_W / 8;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;

    logic          id_q [MAX_OUT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic sel;
    logic req;
    logic is_wr;
    logic fifo_full;
    logic can_issue;
    logic accept;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUT - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // In BUSY the latched owner keeps the port; IDLE picks combinationally.
    always_comb begin
        sel = owner_q;
        if (state_q == IDLE) begin
            if (i_avalid_i && d_avalid_i) begin
`ifdef IOB_VEXRISCV_ARB_DPRIO_EN
                sel = 1'b1;
`else
                sel = ~last_q;
`endif
            end else begin
                sel = d_avalid_i;
            end
        end
    end

    // Full check uses the registered count, so a same-cycle pop cannot help.
    always_comb begin
        req       = sel ? d_avalid_i : i_avalid_i;
        is_wr     = sel & (|d_wstrb_i);
        fifo_full = (cnt_q == CW'(MAX_OUT));
        can_issue = arst_n_i & req & (is_wr | ~fifo_full);
        accept    = can_issue & m_ready_i;
        push      = accept & ~is_wr;
        pop       = arst_n_i & m_rvalid_i & (cnt_q != '0);
        head      = id_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req && !accept) begin
                    state_d = BUSY;
                    owner_d = sel;
                end
            end
            BUSY: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            last_d = sel;
        end
    end

    always_comb begin
        m_avalid_o = can_issue;
        m_addr_o   = sel ? d_addr_i : i_addr_i;
        m_wdata_o  = sel ? d_wdata_i : '0;
        m_wstrb_o  = sel ? d_wstrb_i : '0;
        i_ready_o  = accept & ~sel;
        d_ready_o  = accept & sel;
        i_rvalid_o = pop & ~head;
        d_rvalid_o = pop & head;
        i_rdata_o  = m_rdata_i;
        d_rdata_o  = m_rdata_i;
        err_o      = err_q;
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | (arst_n_i & m_rvalid_i & (cnt_q == '0));
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int k = 0; k < MAX_OUT; k++) begin
                id_q[k] <= 1'b0;
            end
        end else if (push) begin
            id_q[wr_ptr_q] <= sel;
        end
    end

    logic unused_sw;
    assign unused_sw = ^{SW[0]};

endmodule
